// File: rtl/line_fill_unit_if.sv
// Handshake bundles for the line fill unit: cache-side request/done
// and memory-side req/ack. Master drives the request.
interface lfu_cache_if #(
    parameter int ADDR_W = 30
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              busy;
    logic              done;
    logic [127:0]      line_out;
    logic [31:0]       crit_word;
    logic              crit_valid;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  busy, done, line_out, crit_word, crit_valid
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output busy, done, line_out, crit_word, crit_valid
    );
endinterface

interface lfu_mem_if #(
    parameter int ADDR_W = 30
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/line_fill_unit.sv
// Critical-word-first 4-word line fill and write-through word store
// between the data cache miss path and a 32-bit word memory.
module line_fill_unit #(
    parameter int ADDR_W     = 30,
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    lfu_cache_if.slave   cache,
    lfu_mem_if.master    mem
);
    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic              armed_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [2:0]        beats_q, beats_d;
    logic [127:0]      line_q, line_d;
    logic [31:0]       crit_q, crit_d;
    logic              crit_v_q, crit_v_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mreq_q, mreq_d;
    logic              mwe_q, mwe_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [31:0]       mwdata_q, mwdata_d;
    logic              ack;

    // An ack only counts while a request is actually being presented.
    assign ack = mreq_q && mem.mem_ack;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        beats_d  = beats_q;
        line_d   = line_q;
        crit_d   = crit_q;
        crit_v_d = 1'b0;
        done_d   = 1'b0;
        mreq_d   = 1'b0;
        mwe_d    = 1'b0;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        unique case (state_q)
            IDLE: begin
                // armed_q blocks an accept on the reset-release edge.
                if (cache.req_valid && armed_q) begin
                    addr_d  = cache.req_addr;
                    wdata_d = cache.req_wdata;
                    cnt_d   = cache.req_addr[1:0];
                    beats_d = 3'd0;
                    if (cache.req_we) begin
                        state_d = WRITE;
                    end else begin
                        line_d  = '0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (ack) begin
                    line_d[{cnt_q, 5'd0} +: 32] = mem.mem_rdata;
                    cnt_d   = cnt_q + 2'd1;
                    beats_d = beats_q + 3'd1;
                    if (beats_q == 3'd0) begin
                        crit_d   = mem.mem_rdata;
                        crit_v_d = 1'b1;
                    end
                    if (beats_q == 3'(LINE_WORDS - 1)) begin
                        state_d = DONE;
                    end
                end
                mreq_d  = (state_d == FETCH);
                maddr_d = {addr_q[ADDR_W-1:2], cnt_d};
            end
            WRITE: begin
                if (ack) begin
                    state_d = DONE;
                end
                mreq_d   = (state_d == WRITE);
                mwe_d    = mreq_d;
                maddr_d  = addr_q;
                mwdata_d = wdata_q;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            armed_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            beats_q  <= '0;
            line_q   <= '0;
            crit_q   <= '0;
            crit_v_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            armed_q  <= 1'b1;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            beats_q  <= beats_d;
            line_q   <= line_d;
            crit_q   <= crit_d;
            crit_v_q <= crit_v_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    assign cache.busy       = busy_q;
    assign cache.done       = done_q;
    assign cache.line_out   = line_q;
    assign cache.crit_word  = crit_q;
    assign cache.crit_valid = crit_v_q;
    assign mem.mem_req      = mreq_q;
    assign mem.mem_we       = mwe_q;
    assign mem.mem_addr     = maddr_q;
    assign mem.mem_wdata    = mwdata_q;
endmodule
